// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one off-chip memory port between the I-cache refill
// path and the D-cache refill/writeback path.
//
// Transactions are serialized one at a time. When both sides request in
// IDLE, the side that did not own the port last wins (round-robin). All
// memory-side request outputs are registered, so the cache controllers'
// combinational request logic stays off the memory timing path.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_mem_* / d_mem_*          requester sides: read/write/addr/wdata in,
//                              rdata/ready out (ready is a 1-cycle pulse)
//   mem_read/write/addr/wdata  registered request to memory
//   mem_rdata, mem_ready       memory response (ready is a 1-cycle pulse)
//   grant                      01 = I owns the port, 10 = D owns it, 00 = none
//   busy                       high whenever the FSM is not in IDLE
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DONE} state_t;

    state_t state;
    logic   last_d;   // last owner: 0 = I, 1 = D

    logic i_req, d_req, pick_d;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;
    // D wins when it is alone, or on a tie when I owned the port last.
    assign pick_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= OWN_D;
                        last_d    <= 1'b1;
                        mem_addr  <= d_mem_addr;
                        mem_wdata <= d_mem_wdata;
                        mem_write <= d_mem_write;
                        // write takes precedence if both strobes are raised
                        mem_read  <= d_mem_read & ~d_mem_write;
                    end else if (i_req) begin
                        state     <= OWN_I;
                        last_d    <= 1'b0;
                        mem_addr  <= i_mem_addr;
                        mem_wdata <= i_mem_wdata;
                        mem_write <= i_mem_write;
                        mem_read  <= i_mem_read & ~i_mem_write;
                    end
                end
                OWN_I, OWN_D: begin
                    // Memory outputs hold; requester inputs are not re-sampled.
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                DONE: state <= IDLE;   // gives the owner a cycle to drop its request
                default: state <= IDLE;
            endcase
        end
    end

    // Ready and read data route combinationally to the current owner only;
    // a mem_ready outside OWN_I/OWN_D is dropped.
    assign i_mem_ready = (state == OWN_I) & mem_ready;
    assign d_mem_ready = (state == OWN_D) & mem_ready;
    assign i_mem_rdata = (state == OWN_I) ? mem_rdata : '0;
    assign d_mem_rdata = (state == OWN_D) ? mem_rdata : '0;
    assign grant       = {state == OWN_D, state == OWN_I};
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic [DW-1:0] I_WD = 128'h11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_mem_read = 0, i_mem_write = 0;
    logic [AW-1:0] i_mem_addr = '0;
    logic [DW-1:0] i_mem_wdata = I_WD;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;
    logic          d_mem_read = 0, d_mem_write = 0;
    logic [AW-1:0] d_mem_addr = '0;
    logic [DW-1:0] d_mem_wdata = '0;
    logic [DW-1:0] d_mem_rdata;
    logic          d_mem_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 0;
    logic [1:0]    grant;
    logic          busy;

    int n_pass = 0;
    int n_total = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, ir, iw;
        logic [AW-1:0] ia;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic          mrdy;
        logic [DW-1:0] mrd;
        logic          emr, emw;
        logic [AW-1:0] ema;
        logic [DW-1:0] ewd;
        logic [1:0]    egr;
        logic          ebusy, eir, edr;
        logic [DW-1:0] eird, edrd;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic ir, logic iw, logic [AW-1:0] ia,
        logic dr, logic dw, logic [AW-1:0] da, logic [DW-1:0] dwd,
        logic mrdy, logic [DW-1:0] mrd,
        logic emr, logic emw, logic [AW-1:0] ema, logic [DW-1:0] ewd,
        logic [1:0] egr, logic ebusy, logic eir, logic edr,
        logic [DW-1:0] eird, logic [DW-1:0] edrd);
        vec_t v;
        v.rst = rst; v.ir = ir; v.iw = iw; v.ia = ia;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mrdy = mrdy; v.mrd = mrd;
        v.emr = emr; v.emw = emw; v.ema = ema; v.ewd = ewd;
        v.egr = egr; v.ebusy = ebusy; v.eir = eir; v.edr = edr;
        v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] outs();
        return {mem_read, mem_write, mem_addr, mem_wdata, grant, busy,
                i_mem_ready, d_mem_ready, i_mem_rdata, d_mem_rdata};
    endfunction

    task automatic clear_inputs();
        i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    vec_t tbl[$];

    initial begin
        logic [AW-1:0] exp_addr;
        logic [1:0]    exp_gr;
        int            n;

        // Per-cycle vectors: inputs for the cycle, outputs expected in it.
        //                rst ir iw ia      dr dw da      dwd      rdy mrd       mr mw ma      wd      gr    bsy ir dr ird      drd
        // I-side read alone, then a stray mem_ready in IDLE
        tbl.push_back(mk(1, 1, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h0,   'h0,    2'b00, 0, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      1, 0, 'h10,  I_WD,   2'b01, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      1, 0, 'h10,  I_WD,   2'b01, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      1, 0, 'h10,  I_WD,   2'b01, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      1, 0, 'h10,  I_WD,   2'b01, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h10,   0, 0, 'h0,   'h0,     1, 'hA5,     1, 0, 'h10,  I_WD,   2'b01, 1, 1, 0, 'hA5,   'h0));
        tbl.push_back(mk(1, 0, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h10,  I_WD,   2'b00, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 0, 0, 'h10,   0, 0, 'h0,   'h0,     1, 'h77,     0, 0, 'h10,  I_WD,   2'b00, 0, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 0, 0, 'h10,   0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h10,  I_WD,   2'b00, 0, 0, 0, 'h0,    'h0));
        // reset, then simultaneous I read / D write: D wins the first tie
        tbl.push_back(mk(0, 0, 0, 'h0,    0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h0,   'h0,    2'b00, 0, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 1, 'h30,  'h5A,    0, 'h0,      0, 0, 'h0,   'h0,    2'b00, 0, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 1, 'h30,  'h5A,    0, 'h0,      0, 1, 'h30,  'h5A,   2'b10, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 1, 'h30,  'h5A,    1, 'h0,      0, 1, 'h30,  'h5A,   2'b10, 1, 0, 1, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h30,  'h5A,   2'b00, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h30,  'h5A,   2'b00, 0, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 0, 'h0,   'h0,     0, 'h0,      1, 0, 'h20,  I_WD,   2'b01, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 1, 0, 'h20,   0, 0, 'h0,   'h0,     1, 'hCC,     1, 0, 'h20,  I_WD,   2'b01, 1, 1, 0, 'hCC,   'h0));
        tbl.push_back(mk(1, 0, 0, 'h0,    0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h20,  I_WD,   2'b00, 1, 0, 0, 'h0,    'h0));
        // D raises read and write together, then drops both mid-transaction
        tbl.push_back(mk(1, 0, 0, 'h0,    1, 1, 'h55,  'h77,    0, 'h0,      0, 0, 'h20,  I_WD,   2'b00, 0, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 0, 0, 'h0,    0, 0, 'h0,   'h0,     0, 'h0,      0, 1, 'h55,  'h77,   2'b10, 1, 0, 0, 'h0,    'h0));
        tbl.push_back(mk(1, 0, 0, 'h0,    0, 0, 'h0,   'h0,     1, 'h99,     0, 1, 'h55,  'h77,   2'b10, 1, 0, 1, 'h0,    'h99));
        tbl.push_back(mk(1, 0, 0, 'h0,    0, 0, 'h0,   'h0,     0, 'h0,      0, 0, 'h55,  'h77,   2'b00, 1, 0, 0, 'h0,    'h0));

        // reset state
        rst_n = 0;
        @(negedge clk); #2;
        chk("reset_outputs", outs(), '0);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst_n = tbl[k].rst;
            i_mem_read = tbl[k].ir; i_mem_write = tbl[k].iw; i_mem_addr = tbl[k].ia;
            d_mem_read = tbl[k].dr; d_mem_write = tbl[k].dw; d_mem_addr = tbl[k].da;
            d_mem_wdata = tbl[k].dwd;
            mem_ready = tbl[k].mrdy; mem_rdata = tbl[k].mrd;
            #2;
            chk($sformatf("vec%0d", k), outs(),
                {tbl[k].emr, tbl[k].emw, tbl[k].ema, tbl[k].ewd, tbl[k].egr, tbl[k].ebusy,
                 tbl[k].eir, tbl[k].edr, tbl[k].eird, tbl[k].edrd});
        end

        // Both sides request continuously: grants alternate D, I, D, I, ...
        do_reset();
        i_mem_read = 1; i_mem_addr = 'h100;
        d_mem_read = 1; d_mem_addr = 'h200;
        for (int t = 0; t < 6; t++) begin
            exp_gr   = (t % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr = (t % 2 == 0) ? 28'h200 : 28'h100;
            n = 0;
            do begin
                @(negedge clk); #2; n++;
            end while (grant == 2'b00 && n < 20);
            chk($sformatf("rr_grant%0d", t), grant, exp_gr);
            chk($sformatf("rr_addr%0d", t), mem_addr, exp_addr);
            mem_ready = 1; mem_rdata = 128'(t + 1);
            #1;
            chk($sformatf("rr_ready%0d", t), {i_mem_ready, d_mem_ready},
                (exp_gr == 2'b01) ? 2'b10 : 2'b01);
            @(negedge clk);
            mem_ready = 0; mem_rdata = '0;
        end

        // Reset mid OWN_D, between clock edges
        do_reset();
        d_mem_write = 1; d_mem_addr = 'h44; d_mem_wdata = 'h1;
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (grant == 2'b00 && n < 20);
        chk("rst_mid_grant", {grant, mem_write}, {2'b10, 1'b1});
        #1 rst_n = 0;
        #1;
        chk("rst_mid_async", {mem_write, grant, busy, mem_addr}, '0);
        d_mem_write = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mem_ready = 1; mem_rdata = 'hEE;
        #2;
        chk("rst_late_ready", {i_mem_ready, d_mem_ready, grant, d_mem_rdata}, '0);
        @(negedge clk);
        mem_ready = 0;
        #2;
        chk("rst_late_idle", {busy, grant}, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Sits between the two cache controllers and the memory model.
- Serializes transactions, one at a time, with round-robin grant, and routes the ready pulse and read data back to the owning cache.
- Registers all memory-side request outputs so the cache controllers' combinational request logic is off the memory timing path.

Parameters:
- ADDR_W, 28, memory line-address width
- DATA_W, 128, memory line width in bits

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_mem_read  input  1  I-side read request, held until i_mem_ready
- i_mem_write  input  1  I-side write request, held until i_mem_ready
- i_mem_addr  input  ADDR_W  I-side line address
- i_mem_wdata  input  DATA_W  I-side write data
- i_mem_rdata  output  DATA_W  read data to I-side
- i_mem_ready  output  1  I-side completion pulse
- d_mem_read  input  1  D-side read request
- d_mem_write  input  1  D-side write request
- d_mem_addr  input  ADDR_W  D-side line address
- d_mem_wdata  input  DATA_W  D-side write data
- d_mem_rdata  output  DATA_W  read data to D-side
- d_mem_ready  output  1  D-side completion pulse
- mem_read  output  1  registered read strobe to memory
- mem_write  output  1  registered write strobe to memory
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  DATA_W  registered write data
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, one-cycle pulse
- grant  output  2  current owner: 2'b01 = I-side, 2'b10 = D-side, 2'b00 = none
- busy  output  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, OWN_I, OWN_D, DONE. Reset puts the FSM in IDLE.
- Reset is asynchronous. While rst_n is low, or immediately on its assertion (including mid-transaction):
  - state = IDLE, last_owner = I.
  - mem_read, mem_write, mem_addr and mem_wdata are 0.
  - grant = 0, busy = 0, both ready outputs 0.
  - Any in-flight memory transaction is abandoned; a later mem_ready is ignored.
- Request: side X requests when X_mem_read | X_mem_write.
- Arbitration happens in IDLE only:
  - If exactly one side requests, that side wins.
  - If both request, the side that is not last_owner wins. After reset, D wins the first tie.
- Grant edge (IDLE -> OWN_X):
  - last_owner <= X.
  - mem_addr <= X_mem_addr; mem_wdata <= X_mem_wdata.
  - mem_write <= X_mem_write; mem_read <= X_mem_read & ~X_mem_write (write wins if both are asserted; this is a protocol error).
- First cycle of memory strobe: request seen in IDLE in cycle c puts the strobe on the memory port in cycle c+1.
- In OWN_X:
  - Memory outputs are held constant; requester inputs are not re-sampled.
  - When mem_ready = 1: X_mem_ready = 1 in the same cycle (combinational), then next state is DONE.
  - If X drops its request mid-transaction, the transaction still completes and the ready pulse is still issued.
- DONE lasts exactly one cycle:
  - mem_read = mem_write = 0; mem_addr and mem_wdata hold their last values.
  - No grant is made, which lets the owner deassert its request.
  - Next state is IDLE. The earliest new grant is evaluated in the cycle after DONE.
- Read data routing:
  - X_mem_rdata = mem_rdata when grant selects X; otherwise 0.
  - Routing is combinational, with no extra latency.
- mem_ready in IDLE or DONE is ignored: neither ready output fires.
- grant is 01 in OWN_I, 10 in OWN_D, and 00 in IDLE and DONE.
- Minimum turnaround between back-to-back transactions is 3 cycles (ready cycle, DONE, IDLE).

Test Plan:
- Reset, then I-side only: i_mem_read = 1, i_mem_addr = 28'h0000010 at cycle 0 -> mem_read = 1, mem_addr = 28'h0000010 in cycle 1. With memory returning mem_ready in cycle 5 and mem_rdata = 128'hA5 -> i_mem_ready = 1 and i_mem_rdata = 128'hA5 in cycle 5 only; d_mem_ready = 0; mem_read = 0 in cycle 6.
- Simultaneous requests right after reset (I read 28'h20, D write 28'h30 with wdata 128'h5A) -> D is granted first: mem_write = 1, mem_addr = 28'h30. After D completes plus DONE and IDLE, I is granted: mem_read = 1, mem_addr = 28'h20.
- Both sides request continuously for 6 transactions -> grant order is D, I, D, I, D, I; no side waits more than one transaction.
- Stray mem_ready pulse while IDLE -> no ready output fires; state stays IDLE.
- Reset asserted in OWN_D before mem_ready -> mem_write and grant drop to 0 immediately, without waiting for a clock edge. After release, a mem_ready pulse produces no d_mem_ready.
- D asserts both read and write -> only mem_write = 1 on the memory port. D drops its request mid-transaction -> d_mem_ready still pulses on mem_ready.
